// File: rtl/shift_pkg.sv
// Shared constants for the shift arbiter slice: widths, op codes and FSM states.
package shift_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int SHAMT_WIDTH = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/shift_datapath.sv
// Combinational 32-bit barrel shifter: SLL, SRL, SRA, and ROL for op 11 when
// SHIFT_ROTATE_EN is defined (otherwise op 11 executes as SLL).
module shift_datapath
    import shift_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic [1:0]             op,
    output logic [DATA_WIDTH-1:0]  result
);

    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
    logic [DATA_WIDTH-1:0] fill_mask;
    logic                  fill;

    assign left = data << shamt;

    // Right shift is logical; arithmetic shift ORs in the vacated high bits when the sign is set.
    assign fill      = (op == OP_SRA) && data[DATA_WIDTH-1];
    assign fill_mask = ~({DATA_WIDTH{1'b1}} >> shamt);
    assign right     = (data >> shamt) | (fill_mask & {DATA_WIDTH{fill}});

`ifdef SHIFT_ROTATE_EN
    logic [DATA_WIDTH-1:0] rol;

    // A zero amount shifts right by the full width, which yields zero and leaves the operand intact.
    assign rol = left | (data >> (6'(DATA_WIDTH) - {1'b0, shamt}));
`endif

    always_comb begin
        result = left;
        case (op)
            OP_SRL, OP_SRA: result = right;
`ifdef SHIFT_ROTATE_EN
            OP_ROL:         result = rol;
`else
            OP_ROL:         result = left;
`endif
            default:        result = left;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the shared barrel shifter.
// Optional rotate (op 11) is enabled by defining SHIFT_ROTATE_EN.
module shift_arbiter
    import shift_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_shamt,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_shamt,
    input  logic [1:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        busy
);

    state_e                 state;
    logic                   last_grant;
    logic                   grant_en;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  op_data;
    logic [SHAMT_WIDTH-1:0] op_shamt;
    logic [1:0]             op_code;
    logic                   op_id;
    logic [DATA_WIDTH-1:0]  result;

    // Grants open in IDLE, or in DONE when the held result leaves this cycle.
    assign grant_en   = (state == ST_IDLE) || ((state == ST_DONE) && rsp_ready);
    assign req0_ready = grant_en && req0_valid && (!req1_valid || last_grant);
    assign req1_ready = grant_en && req1_valid && (!req0_valid || !last_grant);
    assign accept     = req0_ready || req1_ready;

    // Operand registers carry no reset; they are only consumed after an accept.
    always_ff @(posedge clock) begin
        if (accept) begin
            op_data  <= req1_ready ? req1_data  : req0_data;
            op_shamt <= req1_ready ? req1_shamt : req0_shamt;
            op_code  <= req1_ready ? req1_op    : req0_op;
            op_id    <= req1_ready;
        end
    end

    shift_datapath u_datapath (
        .data   (op_data),
        .shamt  (op_shamt),
        .op     (op_code),
        .result (result)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            busy       <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_BUSY;
                        busy       <= 1'b1;
                        last_grant <= req1_ready;
                    end
                end
                ST_BUSY: begin
                    rsp_data  <= result;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (accept) begin
                            state      <= ST_BUSY;
                            last_grant <= req1_ready;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 32-bit barrel shift datapath.
- Accepts shift requests over valid/ready handshakes, round-robins between the execute-stage ALU (requester 0) and the multdiv unit (requester 1), and registers the operands.
- Drives the combinational shifters, registers the result and returns it tagged with the requester ID.
- Exactly one operation in flight.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- SHAMT_WIDTH, 5, shift amount width; equals log2(DATA_WIDTH).

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a request
- req0_ready  output  1  requester 0 request accepted this edge when valid&ready
- req0_data  input  32  requester 0 operand
- req0_shamt  input  5  requester 0 shift amount
- req0_op  input  2  requester 0 op: 00 SLL, 01 SRL, 10 SRA, 11 ROL/reserved
- req1_valid, req1_ready, req1_data, req1_shamt, req1_op  same as above for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  1  requester that issued the result
- rsp_data  output  32  shifted result
- busy  output  1  high in BUSY or DONE

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high (ports clock, reset).
- Reset values:
  - state=IDLE; rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - req0_ready/req1_ready low except while the IDLE grant rule below selects one.
  - last_grant=1, so requester 0 wins the first tie.
- Reset mid-operation: in-flight request and held result are discarded; no response is ever issued for them.
- States:
  - IDLE: grant logic active; on accept, latch data/shamt/op/id into operand regs -> BUSY.
  - BUSY: shifter evaluates on operand regs; result captured into rsp_data -> DONE. Always exactly one cycle.
  - DONE: rsp_valid=1.
    - rsp_valid&rsp_ready with no request pending -> IDLE.
    - If rsp_ready=1 and a request is pending, the grant is issued in the same cycle (back-to-back) -> BUSY.
    - rsp_ready=0 -> hold DONE; rsp_data/rsp_id stable; both reqN_ready=0.
- Grant rule (combinational, valid only in IDLE, or in DONE with rsp_ready=1):
  - Exactly one reqN_valid -> that readyN=1.
  - Both valid -> grant !last_grant.
  - last_grant updates to the granted ID on accept.
  - At most one readyN high per cycle. Ready must not depend on the request's own op/data.
- Latency: accept edge E0 -> BUSY -> capture at E1 -> rsp_valid high during cycle after E1. Throughput is one op per 2 cycles with continuous rsp_ready.
- Arithmetic:
  - shamt=0 returns the operand unchanged for every op.
  - SLL/SRL zero-fill.
  - SRA replicates bit 31.
  - Amounts are 0..31 only; there is no wrap.
- Requester holds valid/data stable until accepted; dropping valid before accept is legal and simply withdraws the request.

Optional Feature:
- Macro SHIFT_ROTATE_EN.
- Defined: op 11 = ROL, result = (in << n) | (in >> (32-n)), with n=0 giving the operand.
- Undefined: op 11 is executed as SLL, and the rotate logic is absent. Grant/latency are identical in both builds.

Decomposition:
- Package shift_pkg: op encodings (OP_SLL, OP_SRL, OP_SRA, OP_ROL), FSM state encodings (ST_IDLE, ST_BUSY, ST_DONE), DATA_WIDTH/SHAMT_WIDTH constants.
- One sub-module shift_datapath: purely combinational. Instantiates the existing left shifter plus a matching right shifter (arithmetic via fill bit) and the op mux. It holds no state.
- shift_arbiter contains only FSM, arbitration and registers.

Test Plan:
- Reset then req0 SLL data=0x0000_0001 shamt=4, rsp_ready=1 -> req0_ready at E0; rsp_valid in the cycle after E1; rsp_data=0x0000_0010, rsp_id=0.
- req1 SRA data=0x8000_0000 shamt=31 -> rsp_data=0xFFFF_FFFF, rsp_id=1. Same with SRL -> 0x0000_0001.
- Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1. First grant goes to 0 after reset. Never both ready in one cycle.
- rsp_ready=0 for 5 cycles in DONE with req1 pending -> rsp_data/rsp_id stable, req1_ready=0 throughout. On rsp_ready=1, req1 is accepted the same cycle.
- Assert reset during BUSY -> next cycle rsp_valid=0, busy=0, no response emitted. Next tie goes to requester 0.
- op=11 data=0x8000_0001 shamt=1 -> 0x0000_0003 with SHIFT_ROTATE_EN, 0x0000_0002 without.
